// File: rtl/score_rx.sv
// rtl/score_rx.sv - UART 8N1 receiver with two-byte (header, score) packet parser.
// Holds the last well-formed opponent score and pulses score_valid on every update.
module score_rx #(
  parameter int          CLKS_PER_BIT = 6771,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [6:0] op_score,
  output logic       score_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} bit_state_t;
  typedef enum logic       {P_HDR, P_DATA} pkt_state_t;

  logic             rx_meta, rxs;
  bit_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       sr, sr_n;
  logic             byte_done, byte_done_n, frame_err_n;
  pkt_state_t       pstate, pstate_n;
  logic [6:0]       op_score_n;
  logic             score_valid_n;

  // Idle-high reset value keeps a reset release from looking like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sr        <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      sr        <= sr_n;
      byte_done <= byte_done_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    bit_idx_n   = bit_idx;
    sr_n        = sr;
    byte_done_n = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n     = '0;
          sr_n      = {rxs, sr[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (rxs) begin
            byte_done_n = 1'b1;
            state_n     = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = BREAK;
          end
        end
      end
      BREAK: begin
        // A line held low must return high before another start is accepted.
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate      <= P_HDR;
      op_score    <= '0;
      score_valid <= 1'b0;
    end else begin
      pstate      <= pstate_n;
      op_score    <= op_score_n;
      score_valid <= score_valid_n;
    end
  end

  always_comb begin
    pstate_n      = pstate;
    op_score_n    = op_score;
    score_valid_n = 1'b0;
    if (frame_err) begin
      pstate_n = P_HDR;
    end else if (byte_done) begin
      case (pstate)
        P_HDR: begin
          if (sr == HEADER) pstate_n = P_DATA;
        end
        P_DATA: begin
          if (!sr[7]) begin
            op_score_n    = sr[6:0];
            score_valid_n = 1'b1;
            pstate_n      = P_HDR;
          end else if (sr == HEADER) begin
            pstate_n = P_DATA;
          end else begin
            pstate_n = P_HDR;
          end
        end
        default: pstate_n = P_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_score_rx.sv
// tb/tb_score_rx.sv - directed bench for score_rx with CLKS_PER_BIT=16.
module tb_score_rx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [6:0] op_score;
  logic       score_valid;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int sv_count = 0, fe_count = 0, both_count = 0;
  int sv_cyc = -1, fe_cyc = -1;

  score_rx #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .op_score(op_score), .score_valid(score_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (score_valid) begin
      sv_count = sv_count + 1;
      sv_cyc   = cyc;
    end
    if (frame_err) begin
      fe_count = fe_count + 1;
      fe_cyc   = cyc;
    end
    if (score_valid && frame_err) both_count = both_count + 1;
  end

  // Starts on a negedge; start cycle s gives score_valid at s+156, frame_err at s+155.
  task automatic send_byte(input logic [7:0] b, input logic stop, output int s);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    s = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (C) @(negedge clk);
    end
  endtask

  task automatic clear_counts();
    sv_count = 0;
    fe_count = 0;
    sv_cyc   = -1;
    fe_cyc   = -1;
  endtask

  task automatic test_reset();
    int bad_op, bad_sv, bad_fe;
    bad_op = 0; bad_sv = 0; bad_fe = 0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (op_score !== 7'd0) bad_op++;
      if (score_valid !== 1'b0) bad_sv++;
      if (frame_err !== 1'b0) bad_fe++;
    end
    n_cmp++; if (bad_op != 0) begin n_bad++; $display("FAIL reset_op_score: %0d cycles nonzero, required 0", bad_op); end
    n_cmp++; if (bad_sv != 0) begin n_bad++; $display("FAIL reset_score_valid: %0d cycles high, required 0", bad_sv); end
    n_cmp++; if (bad_fe != 0) begin n_bad++; $display("FAIL reset_frame_err: %0d cycles high, required 0", bad_fe); end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    clear_counts();
    send_byte(8'hA5, 1'b1, s1);
    send_byte(8'h2A, 1'b1, s2);
    repeat (10) @(negedge clk);
    n_cmp++; if (op_score !== 7'h2A) begin n_bad++; $display("FAIL b2b_op_score: got %h, required 2a", op_score); end
    n_cmp++; if (sv_count != 1) begin n_bad++; $display("FAIL b2b_sv_count: got %0d, required 1", sv_count); end
    n_cmp++; if (sv_cyc != s2 + 156) begin n_bad++; $display("FAIL b2b_sv_timing: got cycle %0d, required %0d", sv_cyc, s2 + 156); end
    n_cmp++; if (fe_count != 0) begin n_bad++; $display("FAIL b2b_fe_count: got %0d, required 0", fe_count); end
  endtask

  task automatic test_resync();
    int s;
    clear_counts();
    send_byte(8'h2A, 1'b1, s);
    repeat (10) @(negedge clk);
    n_cmp++; if (sv_count != 0) begin n_bad++; $display("FAIL lone_score_sv_count: got %0d, required 0", sv_count); end
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h07, 1'b1, s);
    repeat (10) @(negedge clk);
    n_cmp++; if (op_score !== 7'h07) begin n_bad++; $display("FAIL resync_op_score: got %h, required 07", op_score); end
    n_cmp++; if (sv_count != 1) begin n_bad++; $display("FAIL resync_sv_count: got %0d, required 1", sv_count); end
  endtask

  task automatic test_bad_score();
    int s;
    clear_counts();
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h85, 1'b1, s);
    send_byte(8'h10, 1'b1, s);
    repeat (10) @(negedge clk);
    n_cmp++; if (sv_count != 0) begin n_bad++; $display("FAIL bad_score_sv_count: got %0d, required 0", sv_count); end
    n_cmp++; if (op_score !== 7'h07) begin n_bad++; $display("FAIL bad_score_hold: got %h, required 07", op_score); end
  endtask

  task automatic test_frame_err();
    int s, s2;
    clear_counts();
    send_byte(8'hA5, 1'b0, s);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (fe_count != 1) begin n_bad++; $display("FAIL ferr_count: got %0d, required 1", fe_count); end
    n_cmp++; if (fe_cyc != s + 155) begin n_bad++; $display("FAIL ferr_timing: got cycle %0d, required %0d", fe_cyc, s + 155); end
    n_cmp++; if (sv_count != 0) begin n_bad++; $display("FAIL ferr_sv_count: got %0d, required 0", sv_count); end
    send_byte(8'hA5, 1'b1, s2);
    send_byte(8'h63, 1'b1, s2);
    repeat (10) @(negedge clk);
    n_cmp++; if (op_score !== 7'h63) begin n_bad++; $display("FAIL ferr_recover_op: got %h, required 63", op_score); end
    n_cmp++; if (fe_count != 1) begin n_bad++; $display("FAIL ferr_recover_fe: got %0d, required 1", fe_count); end
  endtask

  task automatic test_glitch();
    clear_counts();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    n_cmp++; if (sv_count != 0 || fe_count != 0) begin n_bad++; $display("FAIL glitch_pulses: sv=%0d fe=%0d, required 0 0", sv_count, fe_count); end
    n_cmp++; if (op_score !== 7'h63) begin n_bad++; $display("FAIL glitch_hold: got %h, required 63", op_score); end
  endtask

  task automatic test_mid_reset();
    int s;
    logic [7:0] b;
    b = 8'h55;
    clear_counts();
    send_byte(8'hA5, 1'b1, s);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = b[3];
    repeat (C / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (op_score !== 7'd0 || score_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs: op=%h sv=%b fe=%b, required 0 0 0", op_score, score_valid, frame_err);
    end
    rst = 1'b0;
    repeat (200) @(negedge clk);
    n_cmp++; if (sv_count != 0 || fe_count != 0) begin n_bad++; $display("FAIL midrst_idle: sv=%0d fe=%0d, required 0 0", sv_count, fe_count); end
    send_byte(8'h33, 1'b1, s);
    repeat (10) @(negedge clk);
    n_cmp++; if (sv_count != 0) begin n_bad++; $display("FAIL midrst_hdr_dropped: got %0d updates, required 0", sv_count); end
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h15, 1'b1, s);
    repeat (10) @(negedge clk);
    n_cmp++; if (op_score !== 7'h15) begin n_bad++; $display("FAIL midrst_recover: got %h, required 15", op_score); end
    n_cmp++; if (sv_count != 1) begin n_bad++; $display("FAIL midrst_sv_count: got %0d, required 1", sv_count); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_resync();
    test_bad_score();
    test_frame_err();
    test_glitch();
    test_mid_reset();
    n_cmp++; if (both_count != 0) begin n_bad++; $display("FAIL pulse_overlap: %0d cycles, required 0", both_count); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_rx.md
# score_rx

Receives the opponent's score over the inter-board UART link and presents it as a registered 7-bit value for the score-comparison stage. It deserialises 8N1 frames, parses a two-byte packet (header, score), and updates the held opponent score only on a well-formed packet. It sits between the board's RX pin and the end-of-game winner logic.

## Interface
- CLKS_PER_BIT, default 6771: clk cycles per UART bit (65 MHz / 9600 baud); must be >= 4.
- HEADER, default 8'hA5: packet header byte; bit7 is set, so it can never be a valid score byte.
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- rx  input  1  asynchronous serial line, idle high.
- op_score  output  7  last valid opponent score; holds between packets.
- score_valid  output  1  one-cycle pulse when op_score is updated, including updates with an unchanged value.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.

## Operation
- Input sync: two-flop synchroniser on rx, both flops reset to 1. All logic uses the synchronised signal `rxs`.
- Bit FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rxs=0 -> START, counter cleared.
  - START: count CLKS_PER_BIT/2 cycles (integer division), then sample. rxs=1 -> IDLE as a false start, with no error. rxs=0 -> DATA, counter cleared, bit index 0.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into a shift register. After bit 7 -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs=1 -> internal byte_done pulse, then IDLE.
    - rxs=0 -> frame_err pulse, byte discarded, BREAK.
  - BREAK: wait for rxs=1, then IDLE. This prevents a held-low line from retriggering.
- Packet parser states: P_HDR, P_DATA. The parser acts only on byte_done.
  - P_HDR: byte==HEADER -> P_DATA. Any other byte is ignored.
  - P_DATA:
    - byte[7]=0 -> op_score <= byte[6:0], score_valid pulse, P_HDR.
    - byte==HEADER -> stay in P_DATA (resync).
    - Other byte with bit7=1 -> P_HDR, no update.
  - A framing error in either state forces P_HDR.
- Counter width: $clog2(CLKS_PER_BIT). The counter saturates at no point; it is cleared on every state change.
- Reset: op_score=0, score_valid=0, frame_err=0, bit FSM=IDLE, parser=P_HDR, shift register=0, counters=0. Reset mid-frame discards the partial byte and any pending header.

## Timing
- Let T0 be the first cycle with rxs=0. rxs lags rx by 2 cycles.
- Sample points relative to T0:
  - Start bit: T0 + CLKS_PER_BIT/2.
  - Data bit n: T0 + CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT.
  - Stop bit: T0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
- byte_done and frame_err are asserted in the cycle after the stop-sample edge.
- op_score and score_valid are registered on the edge following byte_done, which is one further cycle.
- The earliest detection of the next start bit is the first rxs=0 seen in IDLE. Back-to-back frames, with the next start bit immediately after the stop bit, are received without loss.
- score_valid and frame_err are never both high in the same cycle. Both pulses are exactly 1 cycle wide.

## Test plan
Use CLKS_PER_BIT=16 with ideal bit timing unless stated.
- Reset, then rx high for 50 cycles -> op_score=0, score_valid=0, frame_err=0 throughout.
- Send 0xA5, 0x2A back-to-back -> op_score=0x2A, with a single score_valid pulse 2 cycles after the second stop sample. No other pulses.
- Send 0x2A alone -> no update. Then send 0xA5, 0xA5, 0x07 -> op_score=0x07 with one score_valid pulse (resync).
- Send 0xA5, 0x85 -> no update, parser back to P_HDR. Then send 0x10 -> still no update; op_score holds its previous value.
- Send 0xA5 with the stop bit driven 0, then hold rx low for 40 cycles, then high -> one frame_err pulse, no start retrigger during the low hold. Then send 0xA5, 0x63 -> op_score=0x63.
- Glitches and reset:
  - Drive rx low for 4 cycles -> no byte and no frame_err.
  - Assert rst during data bit 3 of a score byte -> all outputs 0, FSMs idle. The next 0xA5, 0x15 -> op_score=0x15.
